// File: rtl/gaussian_sched.sv
// +--------------------------------------------------------------------------+
// | Module  : gaussian_sched                                                 |
// | Brief   : raster-scan window read / filter handshake / writeback         |
// |           scheduler for the gaussian filter path.                        |
// |           Option macro: GAUSS_BORDER_COPY_EN (border pixels copy the     |
// |           window centre byte instead of writing 0).                      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module gaussian_sched #(
  parameter int BITS    = 8,
  parameter int WIDTH   = 7,
  parameter int ADDRLEN = 21,
  parameter int MASKLEN = 392,
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int RD_LAT  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               ren,
  output logic [ADDRLEN-1:0] raddr,
  input  logic [MASKLEN-1:0] rdata,
  output logic               win_valid,
  input  logic               win_ready,
  output logic [MASKLEN-1:0] win_data,
  input  logic               res_valid,
  input  logic [BITS-1:0]    res_pixel,
  output logic               wen,
  output logic [ADDRLEN-1:0] waddr,
  output logic [BITS-1:0]    wdata,
  output logic               writefile
);

  localparam int c_R      = WIDTH / 2;
  localparam int c_COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int c_ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int c_LAT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int c_CENTRE = ((WIDTH * WIDTH) / 2) * BITS;

  localparam logic [c_COL_W-1:0] c_COL_LO   = c_COL_W'(c_R);
  localparam logic [c_COL_W-1:0] c_COL_HI   = c_COL_W'(IMG_W - c_R);
  localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IMG_W - 1);
  localparam logic [c_ROW_W-1:0] c_ROW_LO   = c_ROW_W'(c_R);
  localparam logic [c_ROW_W-1:0] c_ROW_HI   = c_ROW_W'(IMG_H - c_R);
  localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(IMG_H - 1);
  localparam logic [c_LAT_W-1:0] c_LAT_LAST = c_LAT_W'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_NEXT    = 3'd1,
    S_RWAIT   = 3'd2,
    S_ISSUE   = 3'd3,
    S_COLLECT = 3'd4,
    S_WRBORD  = 3'd5,
    S_WRITE   = 3'd6,
    S_FIN     = 3'd7
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_busy;
  logic                 r_done;
  logic [c_ROW_W-1:0]   r_row;
  logic [c_COL_W-1:0]   r_col;
  logic [ADDRLEN-1:0]   r_addr;
  logic [c_LAT_W-1:0]   r_lat_cnt;
  logic [MASKLEN-1:0]   r_win_data;
  logic [BITS-1:0]      r_wdata;

  logic w_border;
  logic w_last;
  logic w_take_read;
  logic w_start_acc;
  logic w_latch;

  assign w_border = (r_row < c_ROW_LO) || (r_row >= c_ROW_HI) ||
                    (r_col < c_COL_LO) || (r_col >= c_COL_HI);
  assign w_last   = (r_row == c_ROW_LAST) && (r_col == c_COL_LAST);

`ifdef GAUSS_BORDER_COPY_EN
  assign w_take_read = 1'b1;
`else
  assign w_take_read = ~w_border;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    ren         = 1'b0;
    win_valid   = 1'b0;
    wen         = 1'b0;
    writefile   = 1'b0;
    w_start_acc = 1'b0;
    w_latch     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_start_acc = 1'b1;
          w_state_nxt = S_NEXT;
        end
      end
      S_NEXT: begin
        if (w_take_read) begin
          ren         = 1'b1;
          w_state_nxt = S_RWAIT;
        end else begin
          w_state_nxt = S_WRBORD;
        end
      end
      S_RWAIT: begin
        if (r_lat_cnt == c_LAT_LAST) begin
          w_latch     = 1'b1;
          // Border reads (copy build only) skip the filter entirely.
          w_state_nxt = w_border ? S_WRITE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        win_valid = 1'b1;
        if (win_ready) w_state_nxt = S_COLLECT;
      end
      S_COLLECT: begin
        if (res_valid) w_state_nxt = S_WRITE;
      end
      S_WRBORD: w_state_nxt = S_WRITE;
      S_WRITE: begin
        wen         = 1'b1;
        w_state_nxt = w_last ? S_FIN : S_NEXT;
      end
      S_FIN: begin
        writefile   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_row      <= '0;
      r_col      <= '0;
      r_addr     <= '0;
      r_lat_cnt  <= '0;
      r_win_data <= '0;
      r_wdata    <= '0;
    end else begin
      if (w_start_acc) begin
        r_busy <= 1'b1;
        r_done <= 1'b0;
        r_row  <= '0;
        r_col  <= '0;
        r_addr <= '0;
      end
      if (r_state == S_FIN) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
      if (r_state == S_NEXT)       r_lat_cnt <= '0;
      else if (r_state == S_RWAIT) r_lat_cnt <= r_lat_cnt + c_LAT_W'(1);
      if (w_latch) begin
        r_win_data <= rdata;
`ifdef GAUSS_BORDER_COPY_EN
        if (w_border) r_wdata <= rdata[c_CENTRE +: BITS];
`endif
      end
      if (r_state == S_WRBORD)             r_wdata <= '0;
      if (r_state == S_COLLECT && res_valid) r_wdata <= res_pixel;
      // Address tracks row*IMG_W+col incrementally; wrap never needs a multiply.
      if (r_state == S_WRITE && !w_last) begin
        r_addr <= r_addr + ADDRLEN'(1);
        if (r_col == c_COL_LAST) begin
          r_col <= '0;
          r_row <= r_row + c_ROW_W'(1);
        end else begin
          r_col <= r_col + c_COL_W'(1);
        end
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign raddr    = r_addr;
  assign waddr    = r_addr;
  assign win_data = r_win_data;
  assign wdata    = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_gaussian_sched.sv
// +--------------------------------------------------------------------------+
// | Module  : tb_gaussian_sched                                              |
// | Brief   : randomized self-checking bench for gaussian_sched (8x8 image,  |
// |           RD_LAT=3); honours GAUSS_BORDER_COPY_EN when defined.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_gaussian_sched;
  localparam int BITS = 8, WIDTH = 7, ADDRLEN = 21, MASKLEN = WIDTH * WIDTH * BITS;
  localparam int IMG_W = 8, IMG_H = 8, RD_LAT = 3, N = IMG_W * IMG_H, R = WIDTH / 2;
  localparam int CB = ((WIDTH * WIDTH) / 2) * BITS;
`ifdef GAUSS_BORDER_COPY_EN
  localparam bit COPY = 1'b1;
`else
  localparam bit COPY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, start, busy, done, ren, win_valid, win_ready, res_valid, wen, writefile;
  logic [ADDRLEN-1:0] raddr, waddr;
  logic [MASKLEN-1:0] rdata, win_data;
  logic [BITS-1:0] res_pixel, wdata;

  gaussian_sched #(.BITS(BITS), .WIDTH(WIDTH), .ADDRLEN(ADDRLEN), .MASKLEN(MASKLEN),
                   .IMG_W(IMG_W), .IMG_H(IMG_H), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .ren(ren), .raddr(raddr), .rdata(rdata),
    .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
    .res_valid(res_valid), .res_pixel(res_pixel),
    .wen(wen), .waddr(waddr), .wdata(wdata), .writefile(writefile));

  always #5 clk = ~clk;

  typedef struct { int cyc; int addr; int data; } ev_t;
  typedef struct { int due; logic [MASKLEN-1:0] data; } rd_t;

  int total = 0, bad = 0, cyc = 0;
  logic [BITS-1:0] res_val = 8'hA5, centre_val = 8'h3C;
  bit rand_ready = 0;
  int stall_addr = -1, stall_left = 0, spur_left = 0, res_due = -1;
  rd_t rd_q[$];
  rd_t rd_item;
  logic [MASKLEN-1:0] drv_win;
  logic [MASKLEN-1:0] win_by_addr [N];
  ev_t wen_log[$], ren_log[$];
  int wf_log[$];
  int win_n, win_bad, overlap, wv_excl_bad;
  int issue_cyc [N];
  logic prev_wv = 1'b0;
  logic [MASKLEN-1:0] prev_wd;
  logic busy_s, done_s;

  // Reference model: border geometry and expected writeback value per address.
  function automatic bit is_border(int a);
    int r, c;
    r = a / IMG_W;
    c = a % IMG_W;
    return (r < R) || (r >= IMG_H - R) || (c < R) || (c >= IMG_W - R);
  endfunction

  function automatic logic [BITS-1:0] exp_pix(int a);
    if (!is_border(a)) return res_val;
    return COPY ? centre_val : '0;
  endfunction

  task automatic rand_window();
    for (int k = 0; k < (MASKLEN + 31) / 32; k++) drv_win = {drv_win[MASKLEN-33:0], $urandom()};
  endtask

  // Buffer and filter models respond 1 time unit after each rising edge.
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      rd_q.delete();
      res_due   = -1;
      rdata     = '0;
      res_valid = 1'b0;
      win_ready = 1'b1;
    end else begin
      if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
        rd_item = rd_q.pop_front();
        rdata   = rd_item.data;
      end else begin
        rand_window();
        drv_win[CB +: BITS] = ~centre_val;
        rdata = drv_win;
      end
      if (ren) begin
        rand_window();
        drv_win[CB +: BITS] = centre_val;
        rd_q.push_back('{due: cyc + RD_LAT, data: drv_win});
        if (int'(raddr) < N) win_by_addr[int'(raddr)] = drv_win;
      end
      if (win_valid && int'(raddr) == stall_addr && stall_left > 0) begin
        win_ready = 1'b0;
        stall_left--;
      end else if (rand_ready) win_ready = ($urandom_range(0, 3) != 0);
      else win_ready = 1'b1;
      res_valid = 1'b0;
      res_pixel = BITS'($urandom());
      if (res_due == cyc) begin
        res_valid = 1'b1;
        res_pixel = res_val;
      end else if (spur_left > 0 && win_valid && !win_ready) begin
        res_valid = 1'b1;
        res_pixel = ~res_val;
        spur_left--;
      end
      if (win_valid && win_ready) res_due = cyc + 2;
    end
  end

  always @(negedge clk) begin
    if (rst) prev_wv = 1'b0;
    else begin
      if (wen) wen_log.push_back('{cyc: cyc, addr: int'(waddr), data: int'(wdata)});
      if (ren) ren_log.push_back('{cyc: cyc, addr: int'(raddr), data: 0});
      if (ren && wen) overlap++;
      if (writefile) wf_log.push_back(cyc);
      if (win_valid && (ren || wen)) wv_excl_bad++;
      if (win_valid) begin
        if (int'(raddr) < N) issue_cyc[int'(raddr)]++;
        if (!prev_wv) begin
          win_n++;
          if (int'(raddr) >= N || win_data !== win_by_addr[int'(raddr)]) win_bad++;
        end else if (win_data !== prev_wd) win_bad++;
      end
      prev_wv = win_valid;
      prev_wd = win_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_frame(input int mid_at, output bit to);
    wen_log.delete(); ren_log.delete(); wf_log.delete();
    win_n = 0; win_bad = 0; overlap = 0; wv_excl_bad = 0;
    for (int i = 0; i < N; i++) issue_cyc[i] = 0;
    start = 1'b1;
    tick();
    start  = 1'b0;
    busy_s = busy;
    done_s = done;
    to = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if (c == mid_at) start = 1'b1;
      tick();
      start = 1'b0;
      if (wf_log.size() > 0) begin
        to = 1'b0;
        break;
      end
    end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({busy, done, ren, raddr, win_valid, win_data, wen, waddr, wdata, writefile} !== '0) begin
        bad++;
        $display("FAIL reset_outputs: busy=%b done=%b ren=%b raddr=%0d wv=%b wen=%b waddr=%0d wdata=%h wf=%b, all must be 0",
                 busy, done, ren, raddr, win_valid, wen, waddr, wdata, writefile);
      end
      tick();
    end
    rst = 1'b0;
    repeat (2) tick();
    total++;
    if ({busy, done, ren, wen, writefile} !== 5'b0) begin
      bad++;
      $display("FAIL idle_after_reset: busy=%b done=%b ren=%b wen=%b wf=%b, required all 0", busy, done, ren, wen, writefile);
    end
  endtask

  task automatic test_mid_frame_reset();
    bit to, hit;
    int dbad;
    res_val = 8'h5E; centre_val = 8'h77;
    start = 1'b1; tick(); start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 2000 && !hit; c++) begin
      tick();
      if (raddr == ADDRLEN'(20)) hit = 1'b1;
    end
    total++;
    if (!hit) begin bad++; $display("FAIL midreset_reach20: pixel 20 never reached within 2000 cycles"); end
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({busy, done, ren, raddr, win_valid, win_data, wen, waddr, wdata, writefile} !== '0) begin
        bad++;
        $display("FAIL midreset_outputs: busy=%b done=%b ren=%b raddr=%0d wen=%b wdata=%h wf=%b, required all 0",
                 busy, done, ren, raddr, wen, wdata, writefile);
      end
      tick();
    end
    rst = 1'b0;
    tick();
    do_frame(-1, to);
    dbad = 0;
    foreach (wen_log[i]) if (wen_log[i].addr != i || wen_log[i].data != int'(exp_pix(i))) dbad++;
    total++;
    if (to || wen_log.size() != N || wen_log[0].addr != 0 || dbad != 0) begin
      bad++;
      $display("FAIL midreset_frame: timeout=%0d writes=%0d first_addr=%0d bad_writes=%0d, required 0/%0d/0/0",
               to, wen_log.size(), (wen_log.size() > 0) ? wen_log[0].addr : -1, dbad, N);
    end
  endtask

  task automatic test_frame();
    bit to;
    int dbad, rbad;
    int exp_ren[$];
    res_val = 8'hA5; centre_val = 8'h3C; rand_ready = 0;
    do_frame(-1, to);
    total++;
    if (to) begin bad++; $display("FAIL frame_timeout: no writefile within budget"); end
    total++;
    if (busy_s !== 1'b1 || done_s !== 1'b0) begin
      bad++; $display("FAIL frame_start_flags: busy=%b done=%b, required busy=1 done=0", busy_s, done_s);
    end
    total++;
    if (wen_log.size() != N) begin bad++; $display("FAIL frame_wen_count: got %0d, required %0d", wen_log.size(), N); end
    dbad = 0;
    foreach (wen_log[i]) if (wen_log[i].addr != i || wen_log[i].data != int'(exp_pix(i))) dbad++;
    total++;
    if (dbad != 0) begin bad++; $display("FAIL frame_write_data: %0d writes wrong addr/data, required 0", dbad); end
    for (int a = 0; a < N; a++) if (!is_border(a) || COPY) exp_ren.push_back(a);
    rbad = 0;
    foreach (ren_log[i]) if (i >= exp_ren.size() || ren_log[i].addr != exp_ren[i]) rbad++;
    total++;
    if (ren_log.size() != exp_ren.size() || rbad != 0) begin
      bad++; $display("FAIL frame_reads: count=%0d wrong_addr=%0d, required count=%0d wrong=0", ren_log.size(), rbad, exp_ren.size());
    end
    total++;
    if (wf_log.size() != 1 || wen_log.size() != N || wf_log[0] != wen_log[N-1].cyc + 1) begin
      bad++;
      $display("FAIL frame_writefile: pulses=%0d at=%0d, required 1 pulse at %0d", wf_log.size(),
               (wf_log.size() > 0) ? wf_log[0] : -1, (wen_log.size() > 0) ? wen_log[wen_log.size()-1].cyc + 1 : -1);
    end
    total++;
    if (overlap != 0) begin bad++; $display("FAIL frame_ren_wen_overlap: %0d cycles, required 0", overlap); end
    total++;
    if (win_n != 4 || win_bad != 0) begin
      bad++; $display("FAIL frame_windows: issued=%0d bad=%0d, required 4/0", win_n, win_bad);
    end
    total++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      bad++; $display("FAIL frame_end_flags: busy=%b done=%b, required busy=0 done=1", busy, done);
    end
  endtask

  task automatic test_stall();
    bit to;
    res_val = 8'h96; centre_val = 8'h1D;
    stall_addr = 27; stall_left = 10;
    do_frame(-1, to);
    stall_addr = -1;
    total++;
    if (to || wen_log.size() != N) begin
      bad++; $display("FAIL stall_frame: timeout=%0d writes=%0d, required 0/%0d", to, wen_log.size(), N);
    end
    total++;
    if (issue_cyc[27] != 11) begin
      bad++; $display("FAIL stall_valid_hold: win_valid cycles at 27 = %0d, required 11", issue_cyc[27]);
    end
    total++;
    if (win_bad != 0 || wv_excl_bad != 0) begin
      bad++; $display("FAIL stall_stability: unstable_or_wrong_windows=%0d ren_wen_during_valid=%0d, required 0/0", win_bad, wv_excl_bad);
    end
  endtask

  task automatic test_ignored_inputs();
    bit to;
    int dbad;
    res_val = 8'hC3; centre_val = 8'h42;
    stall_addr = 36; stall_left = 4; spur_left = 2;
    do_frame(30, to);
    stall_addr = -1; spur_left = 0;
    dbad = 0;
    foreach (wen_log[i]) if (wen_log[i].addr != i || wen_log[i].data != int'(exp_pix(i))) dbad++;
    total++;
    if (to || wen_log.size() != N || dbad != 0 || wf_log.size() != 1) begin
      bad++;
      $display("FAIL ignored_inputs: timeout=%0d writes=%0d bad_writes=%0d writefile=%0d, required 0/%0d/0/1",
               to, wen_log.size(), dbad, wf_log.size(), N);
    end
  endtask

  task automatic test_start_on_fin();
    bit seen;
    int nw;
    res_val = 8'h11; centre_val = 8'h22;
    wen_log.delete(); wf_log.delete();
    start = 1'b1; tick(); start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 4000 && !seen; c++) begin
      tick();
      if (writefile) seen = 1'b1;
    end
    start = 1'b1; tick(); start = 1'b0;
    nw = wen_log.size();
    repeat (6) tick();
    total++;
    if (!seen || busy !== 1'b0 || done !== 1'b1 || wen_log.size() != nw || nw != N) begin
      bad++;
      $display("FAIL start_on_fin: seen=%0d busy=%b done=%b writes=%0d then %0d, required 1/0/1/%0d/%0d",
               seen, busy, done, nw, wen_log.size(), N, N);
    end
  endtask

  task automatic test_random_frames();
    bit to;
    int dbad;
    rand_ready = 1;
    for (int f = 0; f < 3; f++) begin
      res_val    = BITS'($urandom_range(1, 255));
      centre_val = res_val ^ 8'h81;
      do_frame(-1, to);
      dbad = 0;
      foreach (wen_log[i]) if (wen_log[i].addr != i || wen_log[i].data != int'(exp_pix(i))) dbad++;
      total++;
      if (to || wen_log.size() != N || dbad != 0) begin
        bad++; $display("FAIL random_frame%0d: timeout=%0d writes=%0d bad_writes=%0d, required 0/%0d/0", f, to, wen_log.size(), dbad, N);
      end
      total++;
      if (win_n != 4 || win_bad != 0 || overlap != 0) begin
        bad++; $display("FAIL random_frame%0d_windows: issued=%0d bad=%0d overlap=%0d, required 4/0/0", f, win_n, win_bad, overlap);
      end
    end
    rand_ready = 0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    win_ready = 1'b1; res_valid = 1'b0; res_pixel = '0; rdata = '0;
    #1;
    test_reset();
    test_mid_frame_reset();
    test_frame();
    test_stall();
    test_ignored_inputs();
    test_start_on_fin();
    test_random_frames();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
